// File: rtl/wb_spi_ctrl_if.sv
// WishBone classic bus bundle between a bus master and the wb_spi_ctrl slave.
// Signal names follow the WishBone datasheet convention used by the rest of the bus fabric.
interface wb_spi_ctrl_if;
  logic [8:0]  ADR_I;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic        WE_I;
  logic        STB_I;
  logic        CYC_I;
  logic        ACK_O;

  modport master (
    output ADR_I, DAT_I, WE_I, STB_I, CYC_I,
    input  DAT_O, ACK_O
  );

  modport slave (
    input  ADR_I, DAT_I, WE_I, STB_I, CYC_I,
    output DAT_O, ACK_O
  );
endinterface

// File: rtl/wb_spi_ctrl.sv
// WishBone slave that loads a command word, hands it to SPI_MASTER and waits for its ack,
// with sticky status, an interrupt, and a read window onto port A of the SPI result buffer.
module wb_spi_ctrl #(
  parameter logic [15:0] TIMEOUT    = 16'hFFFF,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  wb_spi_ctrl_if.slave       wb,
  output logic               irq,
  output logic [31:0]        cmd_out,
  input  logic               spi_ack,
  output logic [7:0]         buf_addra,
  input  logic [31:0]        buf_douta
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

  localparam logic [15:0] TO_LAST  = TIMEOUT - 16'd1;
  localparam logic [3:0]  GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] cmd_q;
  logic [31:0] cmd_out_q;
  logic [15:0] to_cnt_q;
  logic [3:0]  gap_cnt_q;
  logic [7:0]  count_q;
  logic        done_q, tmo_q, ovr_q, irq_en_q;
  logic        ack_q, buf_pend_q;
  logic [31:0] dat_q;
  logic [7:0]  addr_q;
  logic [31:0] reg_rdata;

  logic req, accept, reg_wr, cmd_wr, ctrl_wr, start_wr, clr_wr, busy;
  logic ack_evt, tmo_evt, ovr_evt;

  // A request stays on the bus through its ACK cycle, so it is only taken when nothing is in flight.
  assign req      = wb.STB_I & wb.CYC_I;
  assign accept   = req & ~ack_q & ~buf_pend_q;
  assign reg_wr   = accept & ~wb.ADR_I[8] & wb.WE_I;
  assign cmd_wr   = reg_wr & (wb.ADR_I[1:0] == 2'd0);
  assign ctrl_wr  = reg_wr & (wb.ADR_I[1:0] == 2'd2);
  assign start_wr = ctrl_wr & wb.DAT_I[0];
  assign clr_wr   = ctrl_wr & wb.DAT_I[1];
  assign busy     = (state_q != IDLE);

  assign ack_evt = (state_q == WAIT) & spi_ack;
  assign tmo_evt = (state_q == WAIT) & ~spi_ack & (to_cnt_q == TO_LAST);
  assign ovr_evt = start_wr & busy;

  assign irq        = irq_en_q & (done_q | tmo_q | ovr_q);
  assign cmd_out    = cmd_out_q;
  assign buf_addra  = req ? wb.ADR_I[7:0] : addr_q;
  assign wb.ACK_O   = ack_q;
  assign wb.DAT_O   = dat_q;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_wr && cmd_q[31:29] != 3'b000) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (ack_evt || tmo_evt) state_d = GAP;
      GAP:     if (gap_cnt_q == GAP_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    reg_rdata = '0;
    case (wb.ADR_I[1:0])
      2'd0:    reg_rdata = cmd_q;
      2'd1:    reg_rdata = {15'd0, irq_en_q, count_q, 4'd0, ovr_q, tmo_q, done_q, busy};
      default: reg_rdata = '0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values,
  // independent of statement order inside the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      cmd_out_q <= '0;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
      ovr_q     <= 1'b0;
      irq_en_q  <= 1'b0;
      ack_q     <= 1'b0;
      buf_pend_q <= 1'b0;
      dat_q     <= '0;
      addr_q    <= '0;
    end else begin
      state_q <= state_d;

      case (state_q)
        ISSUE: begin
          cmd_out_q <= cmd_q;
          to_cnt_q  <= '0;
        end
        WAIT: begin
          to_cnt_q <= to_cnt_q + 16'd1;
          if (ack_evt || tmo_evt) begin
            cmd_out_q <= '0;
            gap_cnt_q <= '0;
          end
        end
        GAP:     gap_cnt_q <= gap_cnt_q + 4'd1;
        default: cmd_out_q <= '0;
      endcase

      // Set events take priority over a same-cycle clear.
      done_q <= ack_evt | (done_q & ~clr_wr);
      tmo_q  <= tmo_evt | (tmo_q  & ~clr_wr);
      ovr_q  <= ovr_evt | (ovr_q  & ~clr_wr);
      if (ack_evt) count_q <= count_q + 8'd1;

      if (cmd_wr && !busy) cmd_q <= wb.DAT_I;
      if (ctrl_wr) irq_en_q <= wb.DAT_I[2];

      if (req) addr_q <= wb.ADR_I[7:0];

      // Buffer reads take one extra cycle for the RAM's registered output.
      ack_q      <= 1'b0;
      buf_pend_q <= 1'b0;
      if (buf_pend_q) begin
        ack_q <= 1'b1;
        dat_q <= buf_douta;
      end else if (accept) begin
        if (wb.ADR_I[8]) begin
          buf_pend_q <= 1'b1;
        end else begin
          ack_q <= 1'b1;
          if (!wb.WE_I) dat_q <= reg_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_spi_ctrl.sv
// Directed self-checking bench for wb_spi_ctrl with a behavioural model of the result buffer's port A.
// Runs with TIMEOUT = 20 so the abort path is reachable in a short run.
module tb_wb_spi_ctrl;

  localparam logic [8:0] A_CMD    = 9'h000;
  localparam logic [8:0] A_STATUS = 9'h001;
  localparam logic [8:0] A_CTRL   = 9'h002;
  localparam logic [8:0] A_RSVD   = 9'h003;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_ack = 1'b0;
  logic        irq;
  logic [31:0] cmd_out;
  logic [7:0]  buf_addra;
  logic [31:0] buf_douta = '0;
  logic [31:0] mem [256];

  int total = 0;
  int bad   = 0;

  wb_spi_ctrl_if wb();

  wb_spi_ctrl #(.TIMEOUT(16'd20), .GAP_CYCLES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb        (wb),
    .irq       (irq),
    .cmd_out   (cmd_out),
    .spi_ack   (spi_ack),
    .buf_addra (buf_addra),
    .buf_douta (buf_douta)
  );

  always #5 clk = ~clk;

  always @(posedge clk) buf_douta <= mem[buf_addra];

  // Drives one classic cycle; holds STB through the ACK cycle and drops it at the next edge.
  task automatic wb_access(input logic we, input logic [8:0] adr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output int lat, output logic ack_after);
    wb.ADR_I = adr;
    wb.DAT_I = wdata;
    wb.WE_I  = we;
    wb.STB_I = 1'b1;
    wb.CYC_I = 1'b1;
    lat = 0;
    while (lat < 8) begin
      @(posedge clk); #1;
      lat++;
      if (wb.ACK_O) break;
    end
    rdata = wb.DAT_O;
    if (!wb.ACK_O) lat = 99;
    @(posedge clk); #1;
    ack_after = wb.ACK_O;
    wb.STB_I = 1'b0;
    wb.CYC_I = 1'b0;
    wb.WE_I  = 1'b0;
  endtask

  task automatic wb_write(input logic [8:0] adr, input logic [31:0] wdata, output int lat);
    logic [31:0] d;
    logic        a;
    wb_access(1'b1, adr, wdata, d, lat, a);
  endtask

  task automatic wb_read(input logic [8:0] adr, output logic [31:0] rdata, output int lat);
    logic a;
    wb_access(1'b0, adr, 32'h0, rdata, lat, a);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_ack();
    spi_ack = 1'b1;
    @(posedge clk); #1;
    spi_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int          lat;
    rst = 1'b1;
    idle(2);
    total++; if (wb.ACK_O !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b want 0", wb.ACK_O); end
    total++; if (wb.DAT_O !== 32'h0) begin bad++; $display("FAIL reset_dat: got %08h want 00000000", wb.DAT_O); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    total++; if (cmd_out !== 32'h0) begin bad++; $display("FAIL reset_cmd_out: got %08h want 00000000", cmd_out); end
    total++; if (buf_addra !== 8'h0) begin bad++; $display("FAIL reset_buf_addra: got %02h want 00", buf_addra); end
    rst = 1'b0;
    idle(1);
    wb_read(A_STATUS, d, lat);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_status: got %08h want 00000000", d); end
    total++; if (lat !== 1) begin bad++; $display("FAIL reset_status_latency: got %0d want 1", lat); end
  endtask

  task automatic test_nop();
    logic [31:0] d;
    int          lat;
    wb_write(A_CTRL, 32'h1, lat);
    idle(2);
    total++; if (cmd_out !== 32'h0) begin bad++; $display("FAIL nop_cmd_out: got %08h want 00000000", cmd_out); end
    pulse_ack();
    idle(1);
    wb_read(A_STATUS, d, lat);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL nop_status: got %08h want 00000000", d); end
    wb_read(A_RSVD, d, lat);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reserved_read: got %08h want 00000000", d); end
  endtask

  task automatic test_cmd_done();
    logic [31:0] d;
    int          lat;
    wb_write(A_CMD, 32'h4154A000, lat);
    wb_read(A_CMD, d, lat);
    total++; if (d !== 32'h4154A000) begin bad++; $display("FAIL cmd_readback: got %08h want 4154A000", d); end
    wb_write(A_CTRL, 32'h5, lat);
    total++; if (cmd_out !== 32'h4154A000) begin bad++; $display("FAIL issue_cmd_out: got %08h want 4154A000", cmd_out); end
    idle(8);
    total++; if (cmd_out !== 32'h4154A000) begin bad++; $display("FAIL wait_cmd_out_held: got %08h want 4154A000", cmd_out); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL wait_irq: got %b want 0", irq); end
    pulse_ack();
    total++; if (cmd_out !== 32'h0) begin bad++; $display("FAIL after_ack_cmd_out: got %08h want 00000000", cmd_out); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL done_irq: got %b want 1", irq); end
    idle(3);
    wb_read(A_STATUS, d, lat);
    total++; if (d !== 32'h00010102) begin bad++; $display("FAIL done_status: got %08h want 00010102", d); end
    wb_write(A_CTRL, 32'h2, lat);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL clear_irq: got %b want 0", irq); end
    wb_read(A_STATUS, d, lat);
    total++; if (d !== 32'h00000100) begin bad++; $display("FAIL clear_status: got %08h want 00000100", d); end
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    int          lat;
    wb_write(A_CTRL, 32'h5, lat);
    idle(19);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL timeout_early: got irq %b want 0", irq); end
    total++; if (cmd_out !== 32'h4154A000) begin bad++; $display("FAIL timeout_cmd_held: got %08h want 4154A000", cmd_out); end
    idle(1);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL timeout_fire: got irq %b want 1", irq); end
    total++; if (cmd_out !== 32'h0) begin bad++; $display("FAIL timeout_cmd_out: got %08h want 00000000", cmd_out); end
    idle(3);
    wb_read(A_STATUS, d, lat);
    total++; if (d !== 32'h00010104) begin bad++; $display("FAIL timeout_status: got %08h want 00010104", d); end
    wb_write(A_CTRL, 32'h2, lat);
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    int          lat;
    wb_write(A_CTRL, 32'h1, lat);
    wb_write(A_CMD, 32'h6154E000, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL busy_cmd_write_ack: got latency %0d want 1", lat); end
    wb_write(A_CTRL, 32'h1, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL busy_start_ack: got latency %0d want 1", lat); end
    pulse_ack();
    idle(3);
    wb_read(A_CMD, d, lat);
    total++; if (d !== 32'h4154A000) begin bad++; $display("FAIL busy_cmd_kept: got %08h want 4154A000", d); end
    wb_read(A_STATUS, d, lat);
    total++; if (d !== 32'h0000020A) begin bad++; $display("FAIL overrun_status: got %08h want 0000020A", d); end
  endtask

  task automatic test_buffer();
    logic [31:0] d;
    int          lat;
    logic        a;
    mem[5] = 32'hDEADBEEF;
    wb.ADR_I = 9'h105;
    wb.WE_I  = 1'b0;
    wb.STB_I = 1'b1;
    wb.CYC_I = 1'b1;
    #1;
    total++; if (buf_addra !== 8'h05) begin bad++; $display("FAIL buf_addra: got %02h want 05", buf_addra); end
    @(posedge clk); #1;
    total++; if (wb.ACK_O !== 1'b0) begin bad++; $display("FAIL buf_ack_early: got %b want 0", wb.ACK_O); end
    @(posedge clk); #1;
    total++; if (wb.ACK_O !== 1'b1) begin bad++; $display("FAIL buf_ack: got %b want 1", wb.ACK_O); end
    total++; if (wb.DAT_O !== 32'hDEADBEEF) begin bad++; $display("FAIL buf_data: got %08h want DEADBEEF", wb.DAT_O); end
    @(posedge clk); #1;
    total++; if (wb.ACK_O !== 1'b0) begin bad++; $display("FAIL buf_ack_single: got %b want 0", wb.ACK_O); end
    wb.STB_I = 1'b0;
    wb.CYC_I = 1'b0;
    wb.ADR_I = 9'h0AA;
    #1;
    total++; if (buf_addra !== 8'h05) begin bad++; $display("FAIL buf_addra_hold: got %02h want 05", buf_addra); end
    wb_access(1'b1, 9'h10A, 32'h12345678, d, lat, a);
    total++; if (lat !== 2) begin bad++; $display("FAIL buf_write_latency: got %0d want 2", lat); end
    total++; if (a !== 1'b0) begin bad++; $display("FAIL buf_write_ack_single: got %b want 0", a); end
    wb_access(1'b0, A_STATUS, 32'h0, d, lat, a);
    total++; if (a !== 1'b0) begin bad++; $display("FAIL reg_ack_single: got %b want 0", a); end
  endtask

  task automatic test_set_wins();
    logic [31:0] d;
    int          lat;
    wb_write(A_CTRL, 32'h1, lat);
    idle(2);
    wb.ADR_I = A_CTRL;
    wb.DAT_I = 32'h2;
    wb.WE_I  = 1'b1;
    wb.STB_I = 1'b1;
    wb.CYC_I = 1'b1;
    spi_ack  = 1'b1;
    @(posedge clk); #1;
    spi_ack = 1'b0;
    total++; if (wb.ACK_O !== 1'b1) begin bad++; $display("FAIL set_wins_ack: got %b want 1", wb.ACK_O); end
    @(posedge clk); #1;
    wb.STB_I = 1'b0;
    wb.CYC_I = 1'b0;
    wb.WE_I  = 1'b0;
    idle(3);
    wb_read(A_STATUS, d, lat);
    total++; if (d !== 32'h00000302) begin bad++; $display("FAIL set_wins_status: got %08h want 00000302", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int          lat;
    wb_write(A_CTRL, 32'h5, lat);
    idle(3);
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (cmd_out !== 32'h0) begin bad++; $display("FAIL reset_mid_cmd_out: got %08h want 00000000", cmd_out); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_mid_irq: got %b want 0", irq); end
    rst = 1'b0;
    idle(1);
    wb_read(A_STATUS, d, lat);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_mid_status: got %08h want 00000000", d); end
    wb_read(A_CMD, d, lat);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_mid_cmd: got %08h want 00000000", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    int          lat;
    wb_write(A_CMD, 32'h4154A000, lat);
    for (int i = 0; i < 256; i++) begin
      wb_write(A_CTRL, 32'h1, lat);
      pulse_ack();
      idle(3);
      if (i == 254) begin
        wb_read(A_STATUS, d, lat);
        total++; if (d !== 32'h0000FF02) begin bad++; $display("FAIL count_255: got %08h want 0000FF02", d); end
      end
    end
    wb_read(A_STATUS, d, lat);
    total++; if (d !== 32'h00000002) begin bad++; $display("FAIL count_wrap: got %08h want 00000002", d); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    wb.ADR_I = '0;
    wb.DAT_I = '0;
    wb.WE_I  = 1'b0;
    wb.STB_I = 1'b0;
    wb.CYC_I = 1'b0;
    #1;
    test_reset();
    test_nop();
    test_cmd_done();
    test_timeout();
    test_overrun();
    test_buffer();
    test_set_wins();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
